// File: rtl/evo_csr_pkg.sv
// Shared widths, FSM state encoding and a small round-robin helper for the
// CSR arbiter and its round-robin selector.
package evo_csr_pkg;

  localparam int CSR_AWIDTH = 8;
  localparam int CSR_DWIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2
  } csr_state_e;

  // Index that gets top priority after a grant to idx, wrapping at n.
  function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/evo_rr_arb.sv
// Round-robin selector: the first requester at or after i_ptr (wrapping) wins.
// Purely combinational; the caller owns and advances the pointer.
module evo_rr_arb #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] w_cand [N];

  // Candidate k is the master k places after the pointer.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_cand[k] = IDX_W'((32'(i_ptr) + 32'(k)) % 32'(N));
    end
  end

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_req[w_cand[k]]) begin
        o_any     = 1'b1;
        o_gnt_idx = w_cand[k];
      end
    end
    o_gnt[o_gnt_idx] = o_any;
  end

endmodule

// File: rtl/evo_csr_arb.sv
// Shares one Avalon-MM CSR slave among NUM_MST masters, one transaction at a
// time, with round-robin grant and a read-timeout that forces a zero completion.
module evo_csr_arb
  import evo_csr_pkg::*;
#(
  parameter int NUM_MST    = 2,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NUM_MST-1:0][CSR_AWIDTH-1:0]  mst_address,
  input  logic [NUM_MST-1:0]                  mst_read,
  input  logic [NUM_MST-1:0]                  mst_write,
  input  logic [NUM_MST-1:0][CSR_DWIDTH-1:0]  mst_writedata,
  output logic [NUM_MST-1:0]                  mst_waitrequest,
  output logic [NUM_MST-1:0]                  mst_readdatavalid,
  output logic [NUM_MST-1:0][CSR_DWIDTH-1:0]  mst_readdata,
  output logic [CSR_AWIDTH-1:0]               csr_address,
  output logic                                csr_read,
  output logic                                csr_write,
  output logic [CSR_DWIDTH-1:0]               csr_writedata,
  input  logic                                csr_waitrequest,
  input  logic                                csr_readdatavalid,
  input  logic [CSR_DWIDTH-1:0]               csr_readdata,
  output logic                                rd_timeout_err,
  output csr_state_e                          o_dbg_state
);

  localparam int IDX_W = $clog2(NUM_MST);
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  // Handshake: a master command is taken on the cycle its mst_waitrequest is
  // low; the slave takes csr_read/csr_write on the cycle csr_waitrequest is low.
  csr_state_e                         r_state;
  csr_state_e                         w_state_nxt;
  logic [IDX_W-1:0]                   r_grant_f;
  logic [NUM_MST-1:0]                 r_grant_oh;
  logic [IDX_W-1:0]                   r_ptr;
  logic [CNT_W-1:0]                   r_cnt;
  logic [NUM_MST-1:0]                 r_rdv;
  logic [NUM_MST-1:0][CSR_DWIDTH-1:0] r_rdata;
  logic                               r_err;

  logic [NUM_MST-1:0]                 w_req;
  logic [NUM_MST-1:0]                 w_arb_gnt;
  logic [IDX_W-1:0]                   w_arb_idx;
  logic                               w_arb_any;
  logic                               w_is_wr;
  logic                               w_is_rd;
  logic                               w_accept;
  logic                               w_rd_done;
  logic                               w_rd_timeout;
  logic                               w_take_grant;

  assign w_req = mst_read | mst_write;

  evo_rr_arb #(
    .N     (NUM_MST),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .i_req     (w_req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_arb_gnt),
    .o_gnt_idx (w_arb_idx),
    .o_any     (w_arb_any)
  );

  // A simultaneous read+write from one master is treated as a write.
  assign w_is_wr      = mst_write[r_grant_f];
  assign w_is_rd      = mst_read[r_grant_f] & ~w_is_wr;
  assign w_accept     = (r_state == ST_ISSUE) & ~csr_waitrequest;
  assign w_rd_done    = (r_state == ST_RDWAIT) & csr_readdatavalid;
  assign w_rd_timeout = (r_state == ST_RDWAIT) & ~csr_readdatavalid & (r_cnt <= CNT_W'(1));
  assign w_take_grant = (r_state == ST_IDLE) & w_arb_any;

  assign csr_address   = mst_address[r_grant_f];
  assign csr_writedata = mst_writedata[r_grant_f];
  assign csr_write     = (r_state == ST_ISSUE) & w_is_wr;
  assign csr_read      = (r_state == ST_ISSUE) & w_is_rd;

  assign mst_waitrequest   = ~(r_grant_oh & {NUM_MST{w_accept}});
  assign mst_readdatavalid = r_rdv;
  assign mst_readdata      = r_rdata;
  assign rd_timeout_err    = r_err;
  assign o_dbg_state       = r_state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_arb_any) w_state_nxt = ST_ISSUE;
      ST_ISSUE:  if (!csr_waitrequest) w_state_nxt = w_is_rd ? ST_RDWAIT : ST_IDLE;
      ST_RDWAIT: if (w_rd_done || w_rd_timeout) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_grant_f  <= '0;
      r_grant_oh <= NUM_MST'(1);
      r_ptr      <= '0;
    end else if (w_take_grant) begin
      r_grant_f  <= w_arb_idx;
      r_grant_oh <= w_arb_gnt;
      r_ptr      <= IDX_W'(rr_next_idx(32'(w_arb_idx), NUM_MST));
    end
  end

  // Counter reaching zero on the last allowed RDWAIT cycle is the timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_accept && w_is_rd) begin
      r_cnt <= CNT_W'(RD_TIMEOUT);
    end else if (w_rd_done || w_rd_timeout) begin
      r_cnt <= '0;
    end else if ((r_state == ST_RDWAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdv   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_rdv <= '0;
      if (w_rd_done || w_rd_timeout) begin
        r_rdv              <= r_grant_oh;
        r_rdata[r_grant_f] <= w_rd_done ? csr_readdata : '0;
      end
      if (w_rd_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/evo_csr_arb.md
EVO_CSR_ARB -- requirements
Module: evo_csr_arb

Interface
REQ-001 SHALL have parameter NUM_MST, default 2, meaning the number of Avalon-MM CSR masters sharing one CSR slave bus (legal range 2..8).
REQ-002 SHALL have parameter RD_TIMEOUT, default 16, meaning the maximum cycles to wait for slave readdatavalid before a forced completion.
REQ-003 SHALL have port clk  input  1  the single clock; all state is on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports mst_address / mst_read / mst_write / mst_writedata  input  [NUM_MST] x CSR_AWIDTH / 1 / 1 / CSR_DWIDTH  per-master command.
REQ-006 SHALL have ports mst_waitrequest / mst_readdatavalid / mst_readdata  output  [NUM_MST] x 1 / 1 / CSR_DWIDTH  per-master response.
REQ-007 SHALL have ports csr_address / csr_read / csr_write / csr_writedata  output  CSR_AWIDTH / 1 / 1 / CSR_DWIDTH  slave-side command.
REQ-008 SHALL have ports csr_waitrequest / csr_readdatavalid / csr_readdata  input  1 / 1 / CSR_DWIDTH  slave-side response.
REQ-009 SHALL have port rd_timeout_err  output  1  sticky flag, set on any read timeout.

Function
REQ-010 SHALL allow one outstanding transaction at a time; FSM states IDLE, ISSUE, RDWAIT.
REQ-011 In IDLE, when any mst_read or mst_write is high, SHALL register the round-robin winner in grant_f and go to ISSUE next cycle; no request keeps IDLE.
REQ-012 Round-robin: priority pointer resets to master 0; after a grant to i, master (i+1) mod NUM_MST has highest priority (wraps NUM_MST-1 -> 0).
REQ-013 In ISSUE, csr_address/csr_writedata/csr_read/csr_write SHALL be driven combinationally from master grant_f; in IDLE and RDWAIT csr_read and csr_write SHALL be 0.
REQ-014 mst_waitrequest[i] SHALL be 0 only when state==ISSUE, grant_f==i and csr_waitrequest==0; otherwise 1.
REQ-015 ISSUE with csr_waitrequest==0: a write returns to IDLE; a read goes to RDWAIT. csr_waitrequest==1 holds ISSUE indefinitely.
REQ-016 Same master asserting mst_read and mst_write together SHALL be issued as a write only.
REQ-017 In RDWAIT, csr_readdatavalid==1 SHALL cause, on the next cycle, mst_readdatavalid[grant_f]=1 for exactly one cycle with mst_readdata[grant_f]=csr_readdata, then IDLE.
REQ-018 A down-counter loaded with RD_TIMEOUT on entry to RDWAIT; on reaching 0 without csr_readdatavalid, SHALL return mst_readdata=0 with a one-cycle mst_readdatavalid, set rd_timeout_err, go IDLE.
REQ-019 csr_readdatavalid in IDLE or ISSUE, or in the cycle after a timeout, SHALL be ignored.
REQ-020 Non-granted masters' mst_readdatavalid SHALL stay 0; mst_readdata SHALL hold its last value.
REQ-021 Latency: write accepted cycle T+1 after request at T (zero-wait slave); read with 1-cycle slave returns mst_readdatavalid at T+3.

Reset
REQ-022 rstn low SHALL asynchronously force: state IDLE, grant_f 0, pointer 0, counter 0, mst_readdatavalid 0, mst_readdata 0, rd_timeout_err 0; hence csr_read/csr_write 0 and all mst_waitrequest 1.
REQ-023 Reset mid-transaction SHALL abandon it with no completion pulse; rd_timeout_err clears only by reset.

Structure
REQ-024 CSR_AWIDTH, CSR_DWIDTH and the FSM state enum SHALL live in the shared package evo_csr_pkg.
REQ-025 Round-robin selection SHALL be one sub-module evo_rr_arb (request vector, pointer in; one-hot grant and index out).

Verification
REQ-026 Master 0 writes 0x2 to address 0 with zero-wait slave at T -> csr_write=1, csr_writedata=0x2 at T+1, mst_waitrequest[0]=0 at T+1 only.
REQ-027 Both masters read every cycle, slave valid 1 cycle after accept -> grants alternate 0,1,0,1; each master's readdata matches its own address.
REQ-028 Master 1 read, slave never asserts readdatavalid -> mst_readdatavalid[1]=1 with data 0 exactly RD_TIMEOUT+1 cycles after accept; rd_timeout_err=1 and stays 1.
REQ-029 Slave holds csr_waitrequest=1 for 5 cycles during master 0 write -> ISSUE held, mst_waitrequest[0]=1 for those cycles, single csr write accepted on cycle 6.
REQ-030 rstn pulsed low in RDWAIT, then slave asserts readdatavalid -> no mst_readdatavalid pulse; all outputs at reset values; next request granted to master 0.
